// File: rtl/bram_sp_arbiter.sv
// ============================================================================
// Module   : bram_sp_arbiter
// Purpose  : Two-port round-robin arbiter (bounded burst) in front of one
//            synchronous single-port BRAM. BRAM_ARB_FIXED_PRIO_EN selects
//            strict port-0 priority instead.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_sp_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  bram_wr,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_data_in,
  input  logic [DATA_WIDTH-1:0] bram_data_out
);

  logic w_gnt0;
  logic w_gnt1;
  logic r_rvalid0;
  logic r_rvalid1;

`ifdef BRAM_ARB_FIXED_PRIO_EN
  assign w_gnt0 = req0;
  assign w_gnt1 = req1 & ~req0;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  localparam int                 c_cnt_w   = $clog2(MAX_BURST) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_BURST - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               r_last_owner;
  logic               w_last_owner_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_owner <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_owner <= w_last_owner_nxt;
    end
  end

  // r_cnt counts grants to the current owner after its first one.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_last_owner_nxt = r_last_owner;
    w_gnt0           = 1'b0;
    w_gnt1           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 && (!req1 || r_last_owner)) begin
          w_gnt0           = 1'b1;
          w_state_nxt      = S_OWN0;
          w_cnt_nxt        = '0;
          w_last_owner_nxt = 1'b0;
        end else if (req1) begin
          w_gnt1           = 1'b1;
          w_state_nxt      = S_OWN1;
          w_cnt_nxt        = '0;
          w_last_owner_nxt = 1'b1;
        end
      end
      S_OWN0: begin
        if (req0 && (!req1 || r_cnt < c_cnt_max)) begin
          w_gnt0 = 1'b1;
          if (r_cnt < c_cnt_max) w_cnt_nxt = r_cnt + 1'b1;
        end else if (req1) begin
          w_gnt1           = 1'b1;
          w_state_nxt      = S_OWN1;
          w_cnt_nxt        = '0;
          w_last_owner_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      S_OWN1: begin
        if (req1 && (!req0 || r_cnt < c_cnt_max)) begin
          w_gnt1 = 1'b1;
          if (r_cnt < c_cnt_max) w_cnt_nxt = r_cnt + 1'b1;
        end else if (req0) begin
          w_gnt0           = 1'b1;
          w_state_nxt      = S_OWN0;
          w_cnt_nxt        = '0;
          w_last_owner_nxt = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end
`endif

  // Grants are forced low while reset is held, even though the FSM is frozen.
  assign gnt0 = w_gnt0 & rst_n;
  assign gnt1 = w_gnt1 & rst_n;

  assign bram_wr      = (gnt0 & wr0) | (gnt1 & wr1);
  assign bram_addr    = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
  assign bram_data_in = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= gnt0 & ~wr0;
      r_rvalid1 <= gnt1 & ~wr1;
    end
  end

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = bram_data_out;

endmodule

`default_nettype wire

// File: tb/tb_bram_sp_arbiter.sv
// ============================================================================
// Module   : tb_bram_sp_arbiter
// Purpose  : Self-checking bench for bram_sp_arbiter with a behavioural BRAM
//            and a streak-based arbitration reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_sp_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          bram_wr;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_data_in;
  logic [DW-1:0] bram_data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bram_sp_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .bram_wr(bram_wr), .bram_addr(bram_addr),
    .bram_data_in(bram_data_in), .bram_data_out(bram_data_out)
  );

  // Behavioural synchronous single-port BRAM
  logic [DW-1:0] bram_mem [2**AW];
  always @(posedge clk) begin
    if (bram_wr) bram_mem[bram_addr] <= bram_data_in;
    bram_data_out <= bram_mem[bram_addr];
  end

  // Reference model: who was granted last cycle (-1 = nobody), how many
  // consecutive cycles that port has been granted, and the last granted port.
  int            m_prev, m_streak, m_last;
  logic [DW-1:0] m_mem   [2**AW];
  bit            m_known [2**AW];
  bit            e_rv0, e_rv1, e_known;
  logic [DW-1:0] e_rdata;

  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (req0 && !req1) return 0;
    if (req1 && !req0) return 1;
    if (!req0 && !req1) return -1;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    return 0;
`else
    if (m_prev < 0) return 1 - m_last;
    if (m_streak < MB) return m_prev;
    return 1 - m_prev;
`endif
  endfunction

  task automatic tick(output int g);
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    g = exp_grant();
    @(posedge clk);
    e_rv0 = 0;
    e_rv1 = 0;
    if (g >= 0) begin
      w = (g == 1) ? wr1 : wr0;
      a = (g == 1) ? addr1 : addr0;
      d = (g == 1) ? wdata1 : wdata0;
      if (w) begin
        m_mem[a]   = d;
        m_known[a] = 1;
      end else begin
        if (g == 0) e_rv0 = 1; else e_rv1 = 1;
        e_rdata = m_mem[a];
        e_known = m_known[a];
      end
      m_streak = (g == m_prev) ? m_streak + 1 : 1;
      m_prev   = g;
      m_last   = g;
    end else begin
      m_prev   = -1;
      m_streak = 0;
    end
    #1;
  endtask

  task automatic model_reset();
    m_prev = -1; m_streak = 0; m_last = 1;
    e_rv0 = 0; e_rv1 = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    req0 = 0; req1 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    req0 = 1; req1 = 1; wr0 = 1; wr1 = 1;
    addr0 = 4'd3; addr1 = 4'd5; wdata0 = 32'h11; wdata1 = 32'h22;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      bad++; $display("FAIL reset_gnt: got %b%b want 00", gnt0, gnt1);
    end
    total++;
    if (bram_wr !== 1'b0 || bram_addr !== '0 || bram_data_in !== '0) begin
      bad++; $display("FAIL reset_mux: got wr=%b addr=%0h din=%0h want 0/0/0", bram_wr, bram_addr, bram_data_in);
    end
    total++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
      bad++; $display("FAIL reset_rvalid: got %b%b want 00", rvalid0, rvalid1);
    end
    req0 = 0; req1 = 0;
    rst_n = 1;
  endtask

  task automatic test_write_read();
    int g;
    req0 = 1; wr0 = 1; addr0 = 4'd6; wdata0 = 32'h5; req1 = 0;
    #1;
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || bram_wr !== 1'b1 || bram_addr !== 4'd6 || bram_data_in !== 32'h5) begin
      bad++; $display("FAIL wr_grant: got gnt=%b%b wr=%b addr=%0h din=%0h want 10/1/6/5", gnt0, gnt1, bram_wr, bram_addr, bram_data_in);
    end
    tick(g);
    wr0 = 0;
    #1;
    total++;
    if (gnt0 !== 1'b1 || bram_wr !== 1'b0) begin
      bad++; $display("FAIL rd_grant: got gnt0=%b wr=%b want 1/0", gnt0, bram_wr);
    end
    tick(g);
    req0 = 0;
    total++;
    if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 32'h5) begin
      bad++; $display("FAIL rd_data: got rv=%b%b rdata=%0h want 10/5", rvalid0, rvalid1, rdata);
    end
    tick(g);
    total++;
    if (rvalid0 !== 1'b0) begin
      bad++; $display("FAIL rd_pulse: got rvalid0=%b want 0", rvalid0);
    end
  endtask

  task automatic test_tie_burst();
    int g;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    int pat [12] = '{0,0,0,0,0,0,0,0,0,0,0,0};
`else
    int pat [12] = '{0,0,0,0,1,1,1,1,0,0,0,0};
`endif
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req0 = 1; req1 = 1; wr0 = 0; wr1 = 0;
      addr0 = AW'($urandom); addr1 = AW'($urandom);
      #1;
      total++;
      if (gnt0 !== (pat[i] == 0) || gnt1 !== (pat[i] == 1)) begin
        bad++; $display("FAIL tie_burst[%0d]: got gnt=%b%b want port %0d", i, gnt0, gnt1, pat[i]);
      end
      total++;
      if (rvalid0 !== e_rv0 || rvalid1 !== e_rv1) begin
        bad++; $display("FAIL tie_rvalid[%0d]: got %b%b want %b%b", i, rvalid0, rvalid1, e_rv0, e_rv1);
      end
      tick(g);
    end
    req0 = 0; req1 = 0;
    tick(g);
  endtask

  task automatic test_saturate();
    int g;
    int eg;
    do_reset();
    req1 = 0; wr0 = 0;
    for (int i = 0; i < 10; i++) begin
      req0 = 1; addr0 = AW'($urandom);
      #1;
      total++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
        bad++; $display("FAIL sat_solo[%0d]: got gnt=%b%b want 10", i, gnt0, gnt1);
      end
      tick(g);
    end
    req1 = 1; wr1 = 0; addr1 = 4'd2;
    #1;
    eg = exp_grant();
    total++;
    if (gnt0 !== (eg == 0) || gnt1 !== (eg == 1)) begin
      bad++; $display("FAIL sat_switch: got gnt=%b%b want port %0d", gnt0, gnt1, eg);
    end
    tick(g);
    req0 = 0; req1 = 0;
    tick(g);
  endtask

  task automatic test_interleave();
    int g;
    req0 = 1; wr0 = 1; addr0 = 4'd1; wdata0 = 32'hA; req1 = 0;
    tick(g);
    req0 = 0; req1 = 1; wr1 = 1; addr1 = 4'd2; wdata1 = 32'hB;
    tick(g);
    req1 = 0; req0 = 1; wr0 = 0; addr0 = 4'd1;
    tick(g);
    req0 = 0; req1 = 1; wr1 = 0; addr1 = 4'd2;
    #1;
    total++;
    if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 32'hA) begin
      bad++; $display("FAIL ilv_port0: got rv=%b%b rdata=%0h want 10/a", rvalid0, rvalid1, rdata);
    end
    tick(g);
    req1 = 0;
    total++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b1 || rdata !== 32'hB) begin
      bad++; $display("FAIL ilv_port1: got rv=%b%b rdata=%0h want 01/b", rvalid0, rvalid1, rdata);
    end
    tick(g);
  endtask

  task automatic test_reset_drop();
    int g;
    req0 = 1; wr0 = 0; addr0 = 4'd6; req1 = 0;
    tick(g);
    rst_n = 0;
    model_reset();
    #1;
    total++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      bad++; $display("FAIL drop_in_reset: got rv=%b%b gnt=%b%b want 00/00", rvalid0, rvalid1, gnt0, gnt1);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    req0 = 1; req1 = 1; wr1 = 0; addr1 = 4'd1;
    #1;
    total++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
      bad++; $display("FAIL drop_after: got rv=%b%b want 00", rvalid0, rvalid1);
    end
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      bad++; $display("FAIL drop_tie: got gnt=%b%b want 10", gnt0, gnt1);
    end
    tick(g);
    req0 = 0; req1 = 0;
    tick(g);
  endtask

  task automatic test_random();
    int  g;
    int  eg;
    bit  p0 = 0;
    bit  p1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1; wr0 = $urandom_range(0, 1) == 1;
        addr0 = AW'($urandom_range(0, 3)); wdata0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 1) == 1) begin
        p1 = 1; wr1 = $urandom_range(0, 1) == 1;
        addr1 = AW'($urandom_range(0, 3)); wdata1 = $urandom;
      end
      req0 = p0; req1 = p1;
      #1;
      eg = exp_grant();
      total++;
      if (gnt0 !== (eg == 0) || gnt1 !== (eg == 1)) begin
        bad++; $display("FAIL rand_gnt[%0d]: got gnt=%b%b want port %0d", i, gnt0, gnt1, eg);
      end
      total++;
      if (bram_wr !== (eg == 0 ? wr0 : eg == 1 ? wr1 : 1'b0) ||
          bram_addr !== (eg == 0 ? addr0 : eg == 1 ? addr1 : '0) ||
          bram_data_in !== (eg == 0 ? wdata0 : eg == 1 ? wdata1 : '0)) begin
        bad++; $display("FAIL rand_mux[%0d]: got wr=%b addr=%0h din=%0h for port %0d", i, bram_wr, bram_addr, bram_data_in, eg);
      end
      total++;
      if (rvalid0 !== e_rv0 || rvalid1 !== e_rv1) begin
        bad++; $display("FAIL rand_rvalid[%0d]: got %b%b want %b%b", i, rvalid0, rvalid1, e_rv0, e_rv1);
      end
      if ((e_rv0 || e_rv1) && e_known) begin
        total++;
        if (rdata !== e_rdata) begin
          bad++; $display("FAIL rand_rdata[%0d]: got %0h want %0h", i, rdata, e_rdata);
        end
      end
      tick(g);
      if (g == 0) p0 = 0;
      if (g == 1) p1 = 0;
    end
    req0 = 0; req1 = 0;
    tick(g);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) m_known[i] = 0;
    e_known = 0;
    e_rdata = '0;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rst_n = 0;
    #1;
    test_reset();
    test_write_read();
    test_tie_burst();
    test_saturate();
    test_interleave();
    test_reset_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
